// File: rtl/adc_conv_scheduler.sv
// Conversion sequencer for the SAR-ADC core with a FWFT result FIFO and sticky error flags.
// Define ADC_SCHED_TIMESTAMP_EN to store a 16-bit cycle timestamp alongside each result.
module adc_conv_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ARM_CYCLES  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode_in,
  input  logic                          start_in,
  input  logic                          stop_in,
  input  logic [15:0]                   interval_in,
  input  logic [15:0]                   timeout_in,
  input  logic                          err_clr_in,
  output logic                          adc_rst_n_out,
  input  logic                          adc_conv_finished_in,
  input  logic [15:0]                   adc_result_in,
  input  logic                          rd_en_in,
  output logic [15:0]                   rd_data_out,
`ifdef ADC_SCHED_TIMESTAMP_EN
  output logic [15:0]                   rd_tstamp_out,
`endif
  output logic                          fifo_empty_out,
  output logic                          fifo_full_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          busy_out,
  output logic                          timeout_err_out,
  output logic                          overflow_err_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [15:0]            cnt_q;
  logic                   mode_lat_q, stop_pend_q;
  logic [15:0]            interval_lat_q, timeout_lat_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   fin_rise, push, timeout_evt;

  // sync_q[0] is the newest sample; the edge is seen on the two oldest flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], adc_conv_finished_in};
  end
  assign fin_rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      S_IDLE:    if (start_in) state_d = S_ARM;
      S_ARM:     if (cnt_q == 16'(ARM_CYCLES - 1)) state_d = S_CONVERT;
      S_CONVERT: begin
        if (fin_rise) begin
          state_d = S_CAPTURE;
        end else if (timeout_lat_q != 16'd0 && cnt_q == timeout_lat_q - 16'd1) begin
          timeout_evt = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_CAPTURE: begin
        push = 1'b1;
        if (!mode_lat_q || stop_pend_q || stop_in) state_d = S_IDLE;
        else if (interval_lat_q == 16'd0)           state_d = S_ARM;
        else                                        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop_in)                                  state_d = S_IDLE;
        else if (cnt_q == interval_lat_q - 16'd1)     state_d = S_ARM;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // cnt_q restarts on every state change and times ARM, CONVERT and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mode_lat_q     <= 1'b0;
      interval_lat_q <= '0;
      timeout_lat_q  <= '0;
      stop_pend_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      if (state_q == S_IDLE && start_in) begin
        mode_lat_q     <= mode_in;
        interval_lat_q <= interval_in;
        timeout_lat_q  <= timeout_in;
      end
      if (state_d == S_IDLE)
        stop_pend_q <= 1'b0;
      else if (stop_in && (state_q == S_ARM || state_q == S_CONVERT))
        stop_pend_q <= 1'b1;
    end
  end

  assign adc_rst_n_out = (state_q == S_CONVERT) || (state_q == S_CAPTURE);
  assign busy_out      = (state_q != S_IDLE);

  // Read side: rd_en_in pops the head when the FIFO is non-empty (valid = !fifo_empty_out);
  // a pop on empty is ignored. A pop in the same cycle as a push frees room for it.
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic [15:0]   last_q;
  logic          full, empty, pop, wr_ok, ovf_evt;

  assign full    = (count_q == LW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = rd_en_in && !empty;
  assign wr_ok   = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= adc_result_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      if (wr_ok && !pop)      count_q <= count_q + LW'(1);
      else if (pop && !wr_ok) count_q <= count_q - LW'(1);
    end
  end

  // When empty the output holds the most recently popped word.
  assign rd_data_out    = empty ? last_q : mem_q[rd_ptr_q];
  assign fifo_empty_out = empty;
  assign fifo_full_out  = full;
  assign fifo_level_out = count_q;

`ifdef ADC_SCHED_TIMESTAMP_EN
  logic [15:0] tstamp_q, last_ts_q;
  logic [15:0] ts_mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_ok) ts_mem_q[wr_ptr_q] <= tstamp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tstamp_q  <= '0;
      last_ts_q <= '0;
    end else begin
      tstamp_q <= tstamp_q + 16'd1;
      if (pop) last_ts_q <= ts_mem_q[rd_ptr_q];
    end
  end

  assign rd_tstamp_out = empty ? last_ts_q : ts_mem_q[rd_ptr_q];
`endif

  // A new error event in the same cycle as err_clr_in keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_out  <= 1'b0;
      overflow_err_out <= 1'b0;
    end else begin
      timeout_err_out  <= (timeout_err_out  & ~err_clr_in) | timeout_evt;
      overflow_err_out <= (overflow_err_out & ~err_clr_in) | ovf_evt;
    end
  end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_adc_conv_scheduler;

  logic        clk, rst;
  logic        mode_in, start_in, stop_in, err_clr_in;
  logic [15:0] interval_in, timeout_in;
  logic        adc_rst_n_out, adc_conv_finished_in;
  logic [15:0] adc_result_in;
  logic        rd_en_in;
  logic [15:0] rd_data_out;
`ifdef ADC_SCHED_TIMESTAMP_EN
  logic [15:0] rd_tstamp_out;
`endif
  logic        fifo_empty_out, fifo_full_out;
  logic [2:0]  fifo_level_out;
  logic        busy_out, timeout_err_out, overflow_err_out;

  adc_conv_scheduler #(.FIFO_DEPTH(4), .SYNC_STAGES(2), .ARM_CYCLES(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mode_in              (mode_in),
    .start_in             (start_in),
    .stop_in              (stop_in),
    .interval_in          (interval_in),
    .timeout_in           (timeout_in),
    .err_clr_in           (err_clr_in),
    .adc_rst_n_out        (adc_rst_n_out),
    .adc_conv_finished_in (adc_conv_finished_in),
    .adc_result_in        (adc_result_in),
    .rd_en_in             (rd_en_in),
    .rd_data_out          (rd_data_out),
`ifdef ADC_SCHED_TIMESTAMP_EN
    .rd_tstamp_out        (rd_tstamp_out),
`endif
    .fifo_empty_out       (fifo_empty_out),
    .fifo_full_out        (fifo_full_out),
    .fifo_level_out       (fifo_level_out),
    .busy_out             (busy_out),
    .timeout_err_out      (timeout_err_out),
    .overflow_err_out     (overflow_err_out)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Scoreboard state
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic        exp_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [15:0] v, input logic pop);
    if (pop && exp_q.size() > 0) exp_q.delete(0);
    if (exp_q.size() < 4) exp_q.push_back(v);
    else exp_ovf = 1'b1;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_convert(input string tag);
    int guard;
    guard = 0;
    while (adc_rst_n_out !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check({tag, "_reach_convert"}, 32'(guard < 200), 32'd1);
  endtask

  // Pulse finished for 4 cycles; optionally assert rd_en_in during the CAPTURE cycle.
  task automatic convert_once(input string tag, input logic [15:0] res, input int delay,
                              input logic rd_at_push);
    wait_convert(tag);
    repeat (delay) tick();
    adc_result_in        = res;
    adc_conv_finished_in = 1'b1;
    tick();
    tick();
    check({tag, "_capture_rstn"}, 32'(adc_rst_n_out), 32'd1);
    rd_en_in = rd_at_push;
    tick();
    rd_en_in = 1'b0;
    tick();
    adc_conv_finished_in = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_head%0d", tag, i), 32'(rd_data_out), 32'(exp_q[0]));
      exp_q.delete(0);
      rd_en_in = 1'b1;
      tick();
      rd_en_in = 1'b0;
    end
    check({tag, "_empty"}, 32'(fifo_empty_out), 32'd1);
  endtask

  // Per-cycle vector table
  typedef struct {
    int          n;
    logic        start, stop, mode, fin, rd, clr;
    logic [15:0] res, tmo;
    logic        exp_rstn, exp_busy;
    logic [2:0]  exp_lvl;
    logic [15:0] exp_data;
    logic        exp_terr, exp_oerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic start, stop, mode, fin, rd, clr,
                     input logic [15:0] res, tmo, input logic rstn, busy,
                     input logic [2:0] lvl, input logic [15:0] data, input logic terr, oerr);
    vec_t v;
    v.n = n; v.start = start; v.stop = stop; v.mode = mode; v.fin = fin; v.rd = rd; v.clr = clr;
    v.res = res; v.tmo = tmo; v.exp_rstn = rstn; v.exp_busy = busy; v.exp_lvl = lvl;
    v.exp_data = data; v.exp_terr = terr; v.exp_oerr = oerr;
    vecs.push_back(v);
  endtask

  task automatic run_table();
    logic [31:0] act, exp;
    foreach (vecs[i]) begin
      start_in             = vecs[i].start;
      stop_in              = vecs[i].stop;
      mode_in              = vecs[i].mode;
      adc_conv_finished_in = vecs[i].fin;
      rd_en_in             = vecs[i].rd;
      err_clr_in           = vecs[i].clr;
      adc_result_in        = vecs[i].res;
      timeout_in           = vecs[i].tmo;
      for (int k = 0; k < vecs[i].n; k++) begin
        tick();
        act = {7'd0, adc_rst_n_out, busy_out, fifo_level_out, rd_data_out,
               fifo_empty_out, fifo_full_out, timeout_err_out, overflow_err_out};
        exp = {7'd0, vecs[i].exp_rstn, vecs[i].exp_busy, vecs[i].exp_lvl, vecs[i].exp_data,
               vecs[i].exp_lvl == 3'd0, vecs[i].exp_lvl == 3'd4, vecs[i].exp_terr, vecs[i].exp_oerr};
        check($sformatf("vec%0d_c%0d", i, k), act, exp);
      end
    end
    start_in = 0; stop_in = 0; mode_in = 0; adc_conv_finished_in = 0;
    rd_en_in = 0; err_clr_in = 0; adc_result_in = 0; timeout_in = 0;
  endtask

`ifdef ADC_SCHED_TIMESTAMP_EN
  task automatic shot_100(input logic [15:0] res);
    mode_in  = 1'b0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (10) tick();
    adc_result_in        = res;
    adc_conv_finished_in = 1'b1;
    repeat (4) tick();
    adc_conv_finished_in = 1'b0;
    repeat (85) tick();
  endtask
`endif

  initial begin
    logic [15:0] t1, t2;
    t1 = '0;
    t2 = '0;
    rst = 1'b1;
    mode_in = 0; start_in = 0; stop_in = 0; interval_in = 0; timeout_in = 0;
    err_clr_in = 0; adc_conv_finished_in = 0; adc_result_in = 0; rd_en_in = 0;
    repeat (3) tick();
    check("reset_state", {7'd0, adc_rst_n_out, busy_out, fifo_level_out, rd_data_out,
                          fifo_empty_out, fifo_full_out, timeout_err_out, overflow_err_out},
          {7'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;

    //   n  st sp md fn rd cl  res       tmo      rstn busy lvl data      terr oerr
    add(1,  1, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  0,   1,   0,  16'h0000, 0,   0);
    add(1,  0, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  0,   1,   0,  16'h0000, 0,   0);
    add(1,  0, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  1,   1,   0,  16'h0000, 0,   0);
    add(19, 1, 0, 1, 0, 0, 0, 16'h0000, 16'd0,  1,   1,   0,  16'h0000, 0,   0);
    add(1,  0, 0, 0, 1, 0, 0, 16'h0ABC, 16'd0,  1,   1,   0,  16'h0000, 0,   0);
    add(1,  0, 0, 0, 1, 0, 0, 16'h0ABC, 16'd0,  1,   1,   0,  16'h0000, 0,   0);
    add(1,  0, 0, 0, 1, 0, 0, 16'h0ABC, 16'd0,  0,   0,   1,  16'h0ABC, 0,   0);
    add(1,  0, 0, 0, 1, 0, 0, 16'h0ABC, 16'd0,  0,   0,   1,  16'h0ABC, 0,   0);
    add(3,  0, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  0,   0,   1,  16'h0ABC, 0,   0);
    add(1,  0, 0, 0, 0, 1, 0, 16'h0000, 16'd0,  0,   0,   0,  16'h0ABC, 0,   0);
    add(1,  0, 0, 0, 0, 1, 0, 16'h0000, 16'd0,  0,   0,   0,  16'h0ABC, 0,   0);
    add(1,  1, 0, 0, 0, 0, 0, 16'h0000, 16'd50, 0,   1,   0,  16'h0ABC, 0,   0);
    add(1,  0, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  0,   1,   0,  16'h0ABC, 0,   0);
    add(1,  0, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  1,   1,   0,  16'h0ABC, 0,   0);
    add(49, 0, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  1,   1,   0,  16'h0ABC, 0,   0);
    add(1,  0, 0, 0, 0, 0, 0, 16'h0000, 16'd0,  0,   0,   0,  16'h0ABC, 1,   0);
    add(1,  0, 0, 0, 0, 0, 1, 16'h0000, 16'd0,  0,   0,   0,  16'h0ABC, 0,   0);
    add(2,  0, 1, 0, 0, 0, 0, 16'h0000, 16'd0,  0,   0,   0,  16'h0ABC, 0,   0);
    run_table();

    // Continuous, interval 10, five results without reads: fifth one overflows.
    mode_in = 1'b1; interval_in = 16'd10; timeout_in = 16'd0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    mode_in  = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      convert_once($sformatf("cont%0d", i), 16'h1111 * 16'(i), 5, 1'b0);
      model_push(16'h1111 * 16'(i), 1'b0);
      check($sformatf("cont%0d_level", i), 32'(fifo_level_out), 32'(exp_q.size()));
      check($sformatf("cont%0d_oerr", i), 32'(overflow_err_out), 32'(exp_ovf));
    end
    check("cont_full", 32'(fifo_full_out), 32'd1);
    check("cont_in_wait", {30'd0, busy_out, adc_rst_n_out}, {30'd0, 1'b1, 1'b0});
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    check("stop_wait_idle", 32'(busy_out), 32'd0);
    repeat (15) tick();
    check("stop_stays_idle", {30'd0, busy_out, adc_rst_n_out}, 32'd0);
    err_clr_in = 1'b1;
    tick();
    err_clr_in = 1'b0;
    exp_ovf = 1'b0;
    check("oerr_cleared", 32'(overflow_err_out), 32'd0);
    drain_and_check("cont_drain");

    // Full FIFO with a pop in the push cycle: level stays, oldest leaves, no overflow.
    mode_in = 1'b1; interval_in = 16'd3;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      convert_once($sformatf("fullrd%0d", i), 16'hA000 + 16'(i), 3, (i == 4));
      model_push(16'hA000 + 16'(i), (i == 4));
    end
    check("fullrd_level", 32'(fifo_level_out), 32'd4);
    check("fullrd_oerr", 32'(overflow_err_out), 32'(exp_ovf));
    check("fullrd_head", 32'(rd_data_out), 32'(exp_q[0]));
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    check("fullrd_stop_idle", 32'(busy_out), 32'd0);
    drain_and_check("fullrd_drain");

    // Asynchronous reset during CONVERT with two entries queued.
    mode_in = 1'b0; interval_in = 16'd0;
    for (int i = 0; i < 2; i++) begin
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      convert_once($sformatf("pre_rst%0d", i), 16'h5A00 + 16'(i), 3, 1'b0);
    end
    check("pre_rst_level", 32'(fifo_level_out), 32'd2);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_convert("rst_mid");
    rst = 1'b1;
    #1;
    check("async_rst_state", {7'd0, adc_rst_n_out, busy_out, fifo_level_out, rd_data_out,
                              fifo_empty_out, fifo_full_out, timeout_err_out, overflow_err_out},
          {7'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef ADC_SCHED_TIMESTAMP_EN
    check("async_rst_tstamp", 32'(rd_tstamp_out), 32'd0);
`endif
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("post_rst_idle", {30'd0, busy_out, fifo_empty_out}, {30'd0, 1'b0, 1'b1});

`ifdef ADC_SCHED_TIMESTAMP_EN
    shot_100(16'h0111);
    shot_100(16'h0222);
    check("ts_level", 32'(fifo_level_out), 32'd2);
    check("ts_data0", 32'(rd_data_out), 32'h0111);
    t1 = rd_tstamp_out;
    rd_en_in = 1'b1;
    tick();
    rd_en_in = 1'b0;
    check("ts_data1", 32'(rd_data_out), 32'h0222);
    t2 = rd_tstamp_out;
    check("ts_delta", 32'(t2 - t1), 32'd100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_conv_scheduler.md
Name: adc_conv_scheduler

Overview:
- Sequences conversions of the SAR-ADC digital core: holds the core in reset, releases it to run one conversion, and waits for its finished strobe.
- Captures each result into a small first-word-fall-through (FWFT) FIFO for the host.
- Supports single-shot and continuous (interval-timed) modes, with a conversion timeout watchdog and sticky error flags.
- Sits between the host register interface and the ADC core instance.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries (power of 2, ≥2).
- SYNC_STAGES, 2, flops synchronizing adc_conv_finished_in into clk domain (≥2).
- ARM_CYCLES, 2, cycles adc_rst_n_out is held low before each conversion (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode_in  in  1  0 = single-shot, 1 = continuous; latched on accepted start
- start_in  in  1  one-cycle start request
- stop_in  in  1  one-cycle stop request
- interval_in  in  16  idle cycles between captures in continuous mode
- timeout_in  in  16  max cycles in CONVERT; 0 disables watchdog
- err_clr_in  in  1  clears sticky error flags
- adc_rst_n_out  out  1  drives ADC core rst_n
- adc_conv_finished_in  in  1  core finished strobe (asynchronous to clk, ≥SYNC_STAGES+1 clk periods wide)
- adc_result_in  in  16  core result, stable while finished is high
- rd_en_in  in  1  pop FIFO head
- rd_data_out  out  16  FIFO head (FWFT)
- fifo_empty_out  out  1  FIFO empty
- fifo_full_out  out  1  FIFO full
- fifo_level_out  out  $clog2(FIFO_DEPTH)+1  entry count
- busy_out  out  1  state ≠ IDLE
- timeout_err_out  out  1  sticky watchdog flag
- overflow_err_out  out  1  sticky FIFO-overflow flag

Behaviour:
- Reset values:
  - adc_rst_n_out = 0, busy_out = 0, rd_data_out = 0, fifo_level_out = 0.
  - fifo_empty_out = 1, fifo_full_out = 0, both error flags = 0, state = IDLE.
- States:
  - IDLE: adc_rst_n_out = 0. On start_in, latch mode_in and go to ARM next cycle.
  - ARM: adc_rst_n_out = 0 for exactly ARM_CYCLES cycles, then go to CONVERT.
  - CONVERT: adc_rst_n_out = 1; watchdog counts from 0. On a synchronized rising edge of finished, go to CAPTURE. If timeout_in ≠ 0 and count reaches timeout_in, set timeout_err_out and go to IDLE (no push).
  - CAPTURE (1 cycle): adc_rst_n_out = 1. Push adc_result_in. Then:
    - single-shot, or stop pending → IDLE;
    - continuous and interval_in = 0 → ARM;
    - otherwise → WAIT.
  - WAIT: adc_rst_n_out = 0. Counts interval_in cycles, then goes to ARM.
- Edge detect: rising edge taken from last two synchronizer flops. Capture occurs SYNC_STAGES+1 clk cycles after finished rises.
- stop_in:
  - In ARM or CONVERT: sets stop-pending; the current conversion completes and is captured.
  - In WAIT: go to IDLE next cycle.
  - In IDLE: ignored.
  - stop-pending is cleared on entering IDLE.
- start_in while busy: ignored. mode_in, interval_in and timeout_in changes mid-run take effect only at the next accepted start (latched at start).
- FIFO:
  - fifo_level_out tracks entry count.
  - Push when full: data dropped, overflow_err_out set.
  - Simultaneous push and pop: pop applied first, so push to a full FIFO is accepted and the level is unchanged.
  - Pop when empty: ignored; rd_data_out holds its last value.
  - Pointers wrap modulo FIFO_DEPTH.
- Errors: err_clr_in clears both flags. If err_clr_in coincides with a new error event, the set wins.
- rst mid-conversion: immediate return to IDLE, adc_rst_n_out = 0, FIFO flushed.

Optional Feature:
- ADC_SCHED_TIMESTAMP_EN defined:
  - Adds a free-running 16-bit cycle counter (wraps at 0xFFFF→0, cleared by rst).
  - At each push, the counter value is stored alongside the result.
  - Adds output port rd_tstamp_out (16 bits, reset 0), FWFT with rd_data_out.
- Undefined: no counter, no port, no extra storage.

Test Plan:
- Single-shot: mode 0, start; finished pulse (4 cycles) carrying 0x0ABC after 20 cycles → adc_rst_n_out low 2 cycles then high; push 3 cycles after edge; rd_data_out = 0x0ABC, level = 1; back to IDLE with adc_rst_n_out = 0.
- Continuous: mode 1, interval 10, five finished pulses, no reads → level 4, full, 5th result dropped, overflow_err_out = 1; stop during WAIT → IDLE next cycle.
- Timeout: timeout_in = 50, no finished pulse → timeout_err_out set at cycle 50 of CONVERT, IDLE, FIFO unchanged; err_clr_in → flag 0.
- Full FIFO with rd_en_in in the push cycle → level stays 4, oldest entry popped, new entry stored, no overflow flag.
- rst asserted in CONVERT with 2 entries queued → all outputs to reset values in the same cycle (asynchronous), FIFO empty.
- ADC_SCHED_TIMESTAMP_EN: two captures 100 cycles apart → rd_tstamp_out difference = 100.
